// File: rtl/usb_sniffer_axi_arb_pkg.sv
// Shared types and constants for the two-port USB sniffer AXI request arbiter.
package usb_sniffer_axi_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_BURST = 2'd2
  } arb_state_t;

  localparam int ID_PORT_BIT = 3;
  localparam int BEATS_W     = 8;

  // id[3] is not carried: it is replaced by the source port on the way out.
  typedef struct packed {
    logic               valid;
    logic               write;
    logic [31:0]        addr;
    logic [2:0]         id;
    logic [BEATS_W-1:0] len;
    logic [1:0]         burst;
    logic [31:0]        wdata;
    logic [3:0]         wstrb;
  } req_t;

endpackage

// File: rtl/usb_sniffer_axi_arb_rr.sv
// Two-way round-robin picker: one-hot grant from a request pair and a pointer.
module usb_sniffer_axi_arb_rr #(
  parameter int FIXED_PRIO = 0
) (
  input  logic [1:0] i_request,
  input  logic       i_rr,
  output logic [1:0] o_grant
);

  always_comb begin
    o_grant = 2'b00;
    case (i_request)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      2'b11:   o_grant = ((FIXED_PRIO != 0) || !i_rr) ? 2'b01 : 2'b10;
      default: o_grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/usb_sniffer_axi_arb.sv
// Two-port AXI-style request arbiter with burst locking and ID-based response routing.
module usb_sniffer_axi_arb
  import usb_sniffer_axi_arb_pkg::*;
#(
  parameter int FIXED_PRIO = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic        in0_valid_i,
  input  logic        in0_write_i,
  input  logic [31:0] in0_addr_i,
  input  logic [3:0]  in0_id_i,
  input  logic [7:0]  in0_len_i,
  input  logic [1:0]  in0_burst_i,
  input  logic [31:0] in0_wdata_i,
  input  logic [3:0]  in0_wstrb_i,
  output logic        in0_accept_o,
  output logic        in0_bvalid_o,
  output logic [1:0]  in0_bresp_o,
  output logic [3:0]  in0_bid_o,
  input  logic        in0_bready_i,
  output logic        in0_rvalid_o,
  output logic [31:0] in0_rdata_o,
  output logic [1:0]  in0_rresp_o,
  output logic [3:0]  in0_rid_o,
  output logic        in0_rlast_o,
  input  logic        in0_rready_i,

  input  logic        in1_valid_i,
  input  logic        in1_write_i,
  input  logic [31:0] in1_addr_i,
  input  logic [3:0]  in1_id_i,
  input  logic [7:0]  in1_len_i,
  input  logic [1:0]  in1_burst_i,
  input  logic [31:0] in1_wdata_i,
  input  logic [3:0]  in1_wstrb_i,
  output logic        in1_accept_o,
  output logic        in1_bvalid_o,
  output logic [1:0]  in1_bresp_o,
  output logic [3:0]  in1_bid_o,
  input  logic        in1_bready_i,
  output logic        in1_rvalid_o,
  output logic [31:0] in1_rdata_o,
  output logic [1:0]  in1_rresp_o,
  output logic [3:0]  in1_rid_o,
  output logic        in1_rlast_o,
  input  logic        in1_rready_i,

  output logic        out_valid_o,
  output logic        out_write_o,
  output logic [31:0] out_addr_o,
  output logic [3:0]  out_id_o,
  output logic [7:0]  out_len_o,
  output logic [1:0]  out_burst_o,
  output logic [31:0] out_wdata_o,
  output logic [3:0]  out_wstrb_o,
  input  logic        out_accept_i,
  input  logic        out_bvalid_i,
  input  logic [1:0]  out_bresp_i,
  input  logic [3:0]  out_bid_i,
  output logic        out_bready_o,
  input  logic        out_rvalid_i,
  input  logic [31:0] out_rdata_i,
  input  logic [1:0]  out_rresp_i,
  input  logic [3:0]  out_rid_i,
  input  logic        out_rlast_i,
  output logic        out_rready_o
);

  req_t               w_req [2];
  logic [1:0]         w_req_valid;
  logic [1:0]         w_pick;
  logic               w_sel;
  req_t               w_gnt_req;
  logic               w_fire;
  logic               w_burst_start;
  logic [1:0]         w_accept;
  logic               w_unused_id_msb;

  arb_state_t         r_state;
  logic [BEATS_W-1:0] r_beats;
  logic               r_rr;
  logic               r_grant;

  assign w_req[0] = {in0_valid_i, in0_write_i, in0_addr_i, in0_id_i[2:0], in0_len_i,
                     in0_burst_i, in0_wdata_i, in0_wstrb_i};
  assign w_req[1] = {in1_valid_i, in1_write_i, in1_addr_i, in1_id_i[2:0], in1_len_i,
                     in1_burst_i, in1_wdata_i, in1_wstrb_i};
  // Requesters keep id[3] low; the arbiter overwrites it with the port number.
  assign w_unused_id_msb = in0_id_i[3] ^ in1_id_i[3];

  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    assign w_req_valid[gi] = w_req[gi].valid;
    assign w_accept[gi]    = w_fire && (w_sel == 1'(gi));
  end

  usb_sniffer_axi_arb_rr #(
    .FIXED_PRIO (FIXED_PRIO)
  ) u_rr (
    .i_request (w_req_valid),
    .i_rr      (r_rr),
    .o_grant   (w_pick)
  );

  // Only IDLE picks freshly; HOLD and BURST stay on the frozen grant.
  assign w_sel         = (r_state == ST_IDLE) ? w_pick[1] : r_grant;
  assign w_gnt_req     = w_req[w_sel];
  assign w_fire        = w_gnt_req.valid && out_accept_i;
  assign w_burst_start = w_gnt_req.write && (w_gnt_req.len != '0);

  assign out_valid_o  = w_gnt_req.valid;
  assign out_write_o  = w_gnt_req.write;
  assign out_addr_o   = w_gnt_req.addr;
  assign out_id_o     = {w_sel, w_gnt_req.id};
  assign out_len_o    = w_gnt_req.len;
  assign out_burst_o  = w_gnt_req.burst;
  assign out_wdata_o  = w_gnt_req.wdata;
  assign out_wstrb_o  = w_gnt_req.wstrb;
  assign in0_accept_o = w_accept[0];
  assign in1_accept_o = w_accept[1];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_beats <= '0;
      r_rr    <= 1'b0;
      r_grant <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_HOLD: begin
          if (!w_gnt_req.valid) begin
            r_state <= ST_IDLE;
          end else if (w_fire) begin
            r_grant <= w_sel;
            if (w_burst_start) begin
              r_state <= ST_BURST;
              r_beats <= w_gnt_req.len;
            end else begin
              r_state <= ST_IDLE;
              r_rr    <= ~w_sel;
            end
          end else begin
            r_state <= ST_HOLD;
            r_grant <= w_sel;
          end
        end
        ST_BURST: begin
          if (w_fire) begin
            r_beats <= r_beats - BEATS_W'(1);
            if (r_beats == BEATS_W'(1)) begin
              r_state <= ST_IDLE;
              r_rr    <= ~r_grant;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // A granted requester must not withdraw its request before it is accepted.
  a_hold_keeps_valid: assert property (@(posedge clk_i) disable iff (rst_i)
    (r_state == ST_HOLD) |-> w_gnt_req.valid);

  logic       w_b_port;
  logic       w_r_port;
  logic [1:0] w_bready;
  logic [1:0] w_rready;

  assign w_b_port = out_bid_i[ID_PORT_BIT];
  assign w_r_port = out_rid_i[ID_PORT_BIT];
  assign w_bready = {in1_bready_i, in0_bready_i};
  assign w_rready = {in1_rready_i, in0_rready_i};

  assign in0_bvalid_o = out_bvalid_i && !w_b_port;
  assign in1_bvalid_o = out_bvalid_i && w_b_port;
  assign in0_bid_o    = {1'b0, out_bid_i[2:0]};
  assign in1_bid_o    = {1'b0, out_bid_i[2:0]};
  assign in0_bresp_o  = out_bresp_i;
  assign in1_bresp_o  = out_bresp_i;
  assign out_bready_o = w_bready[w_b_port];

  assign in0_rvalid_o = out_rvalid_i && !w_r_port;
  assign in1_rvalid_o = out_rvalid_i && w_r_port;
  assign in0_rid_o    = {1'b0, out_rid_i[2:0]};
  assign in1_rid_o    = {1'b0, out_rid_i[2:0]};
  assign in0_rdata_o  = out_rdata_i;
  assign in1_rdata_o  = out_rdata_i;
  assign in0_rresp_o  = out_rresp_i;
  assign in1_rresp_o  = out_rresp_i;
  assign in0_rlast_o  = out_rlast_i;
  assign in1_rlast_o  = out_rlast_i;
  assign out_rready_o = w_rready[w_r_port];

endmodule

// File: tb/tb_usb_sniffer_axi_arb.sv
// Self-checking bench: per-cycle vector table plus a scoreboard of accepted request beats.
module tb_usb_sniffer_axi_arb;

  logic        clk = 1'b0;
  logic        rst, f_rst;
  logic        in0_valid, in0_write, in1_valid, in1_write;
  logic [31:0] in0_addr, in1_addr, in0_wdata, in1_wdata;
  logic [3:0]  in0_id, in1_id, in0_wstrb, in1_wstrb;
  logic [7:0]  in0_len, in1_len;
  logic [1:0]  in0_burst, in1_burst;
  logic        in0_bready, in1_bready, in0_rready, in1_rready;
  logic        out_accept, out_bvalid, out_rvalid, out_rlast;
  logic [1:0]  out_bresp, out_rresp;
  logic [3:0]  out_bid, out_rid;
  logic [31:0] out_rdata;

  // main DUT outputs
  logic        m_in0_accept, m_in0_bvalid, m_in0_rvalid, m_in0_rlast;
  logic        m_in1_accept, m_in1_bvalid, m_in1_rvalid, m_in1_rlast;
  logic [1:0]  m_in0_bresp, m_in0_rresp, m_in1_bresp, m_in1_rresp;
  logic [3:0]  m_in0_bid, m_in0_rid, m_in1_bid, m_in1_rid;
  logic [31:0] m_in0_rdata, m_in1_rdata;
  logic        m_out_valid, m_out_write, m_out_bready, m_out_rready;
  logic [31:0] m_out_addr, m_out_wdata;
  logic [3:0]  m_out_id, m_out_wstrb;
  logic [7:0]  m_out_len;
  logic [1:0]  m_out_burst;

  // fixed-priority DUT outputs
  logic        f_in0_accept, f_in0_bvalid, f_in0_rvalid, f_in0_rlast;
  logic        f_in1_accept, f_in1_bvalid, f_in1_rvalid, f_in1_rlast;
  logic [1:0]  f_in0_bresp, f_in0_rresp, f_in1_bresp, f_in1_rresp;
  logic [3:0]  f_in0_bid, f_in0_rid, f_in1_bid, f_in1_rid;
  logic [31:0] f_in0_rdata, f_in1_rdata;
  logic        f_out_valid, f_out_write, f_out_bready, f_out_rready;
  logic [31:0] f_out_addr, f_out_wdata;
  logic [3:0]  f_out_id, f_out_wstrb;
  logic [7:0]  f_out_len;
  logic [1:0]  f_out_burst;

  always #5 clk = ~clk;

  usb_sniffer_axi_arb #(.FIXED_PRIO(0)) u_dut (
    .clk_i(clk), .rst_i(rst),
    .in0_valid_i(in0_valid), .in0_write_i(in0_write), .in0_addr_i(in0_addr), .in0_id_i(in0_id),
    .in0_len_i(in0_len), .in0_burst_i(in0_burst), .in0_wdata_i(in0_wdata), .in0_wstrb_i(in0_wstrb),
    .in0_accept_o(m_in0_accept), .in0_bvalid_o(m_in0_bvalid), .in0_bresp_o(m_in0_bresp),
    .in0_bid_o(m_in0_bid), .in0_bready_i(in0_bready), .in0_rvalid_o(m_in0_rvalid),
    .in0_rdata_o(m_in0_rdata), .in0_rresp_o(m_in0_rresp), .in0_rid_o(m_in0_rid),
    .in0_rlast_o(m_in0_rlast), .in0_rready_i(in0_rready),
    .in1_valid_i(in1_valid), .in1_write_i(in1_write), .in1_addr_i(in1_addr), .in1_id_i(in1_id),
    .in1_len_i(in1_len), .in1_burst_i(in1_burst), .in1_wdata_i(in1_wdata), .in1_wstrb_i(in1_wstrb),
    .in1_accept_o(m_in1_accept), .in1_bvalid_o(m_in1_bvalid), .in1_bresp_o(m_in1_bresp),
    .in1_bid_o(m_in1_bid), .in1_bready_i(in1_bready), .in1_rvalid_o(m_in1_rvalid),
    .in1_rdata_o(m_in1_rdata), .in1_rresp_o(m_in1_rresp), .in1_rid_o(m_in1_rid),
    .in1_rlast_o(m_in1_rlast), .in1_rready_i(in1_rready),
    .out_valid_o(m_out_valid), .out_write_o(m_out_write), .out_addr_o(m_out_addr),
    .out_id_o(m_out_id), .out_len_o(m_out_len), .out_burst_o(m_out_burst),
    .out_wdata_o(m_out_wdata), .out_wstrb_o(m_out_wstrb), .out_accept_i(out_accept),
    .out_bvalid_i(out_bvalid), .out_bresp_i(out_bresp), .out_bid_i(out_bid),
    .out_bready_o(m_out_bready), .out_rvalid_i(out_rvalid), .out_rdata_i(out_rdata),
    .out_rresp_i(out_rresp), .out_rid_i(out_rid), .out_rlast_i(out_rlast),
    .out_rready_o(m_out_rready)
  );

  usb_sniffer_axi_arb #(.FIXED_PRIO(1)) u_dut_fixed (
    .clk_i(clk), .rst_i(f_rst),
    .in0_valid_i(in0_valid), .in0_write_i(in0_write), .in0_addr_i(in0_addr), .in0_id_i(in0_id),
    .in0_len_i(in0_len), .in0_burst_i(in0_burst), .in0_wdata_i(in0_wdata), .in0_wstrb_i(in0_wstrb),
    .in0_accept_o(f_in0_accept), .in0_bvalid_o(f_in0_bvalid), .in0_bresp_o(f_in0_bresp),
    .in0_bid_o(f_in0_bid), .in0_bready_i(in0_bready), .in0_rvalid_o(f_in0_rvalid),
    .in0_rdata_o(f_in0_rdata), .in0_rresp_o(f_in0_rresp), .in0_rid_o(f_in0_rid),
    .in0_rlast_o(f_in0_rlast), .in0_rready_i(in0_rready),
    .in1_valid_i(in1_valid), .in1_write_i(in1_write), .in1_addr_i(in1_addr), .in1_id_i(in1_id),
    .in1_len_i(in1_len), .in1_burst_i(in1_burst), .in1_wdata_i(in1_wdata), .in1_wstrb_i(in1_wstrb),
    .in1_accept_o(f_in1_accept), .in1_bvalid_o(f_in1_bvalid), .in1_bresp_o(f_in1_bresp),
    .in1_bid_o(f_in1_bid), .in1_bready_i(in1_bready), .in1_rvalid_o(f_in1_rvalid),
    .in1_rdata_o(f_in1_rdata), .in1_rresp_o(f_in1_rresp), .in1_rid_o(f_in1_rid),
    .in1_rlast_o(f_in1_rlast), .in1_rready_i(in1_rready),
    .out_valid_o(f_out_valid), .out_write_o(f_out_write), .out_addr_o(f_out_addr),
    .out_id_o(f_out_id), .out_len_o(f_out_len), .out_burst_o(f_out_burst),
    .out_wdata_o(f_out_wdata), .out_wstrb_o(f_out_wstrb), .out_accept_i(out_accept),
    .out_bvalid_i(out_bvalid), .out_bresp_i(out_bresp), .out_bid_i(out_bid),
    .out_bready_o(f_out_bready), .out_rvalid_i(out_rvalid), .out_rdata_i(out_rdata),
    .out_rresp_i(out_rresp), .out_rid_i(out_rid), .out_rlast_i(out_rlast),
    .out_rready_o(f_out_rready)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit       rst;
    bit       v0;
    bit       v1;
    bit       wr0;
    bit [7:0] len0;
    bit       acc;
    bit       bv;
    bit [3:0] bid;
    bit       e_valid;
    bit       e_port;
    bit       e_a0;
    bit       e_a1;
  } vec_t;

  typedef struct {
    bit [31:0] addr;
    bit [3:0]  id;
    bit        write;
  } beat_t;

  vec_t  vecs[$];
  beat_t sb[$];

  function automatic void add(bit r, bit v0, bit v1, bit wr0, bit [7:0] len0, bit acc,
                              bit bv, bit [3:0] bid, bit ev, bit ep, bit ea0, bit ea1);
    vec_t v;
    v = '{r, v0, v1, wr0, len0, acc, bv, bid, ev, ep, ea0, ea1};
    vecs.push_back(v);
  endfunction

  // Port 0 drives id 4'hD (msb must be ignored), port 1 drives id 4'h3.
  function automatic beat_t exp_beat(bit port, int idx, bit wr0);
    beat_t b;
    b.addr  = port ? 32'h2000_0000 + 32'(idx) : 32'h1000_0000 + 32'(idx);
    b.id    = port ? 4'hB : 4'h5;
    b.write = port ? 1'b0 : wr0;
    return b;
  endfunction

  task automatic drive(int idx, bit r, bit v0, bit v1, bit wr0, bit [7:0] len0, bit acc,
                       bit bv, bit [3:0] bid);
    rst        = r;
    in0_valid  = v0;  in0_write = wr0;  in0_len = len0;
    in1_valid  = v1;  in1_write = 1'b0; in1_len = 8'd0;
    in0_addr   = 32'h1000_0000 + 32'(idx);
    in1_addr   = 32'h2000_0000 + 32'(idx);
    in0_wdata  = 32'hA0A0_0000 + 32'(idx);
    in1_wdata  = 32'hB0B0_0000 + 32'(idx);
    out_accept = acc;
    out_bvalid = bv;  out_bid = bid;
    out_rvalid = bv;  out_rid = bid;
    out_rdata  = 32'hCAFE_0000 + 32'(idx);
  endtask

  // Scoreboard: every accepted request beat must match the oldest expected beat.
  always @(negedge clk) begin
    if (m_out_valid && out_accept) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_beat", {32'd0, m_out_addr}, 64'd0);
      end else begin
        beat_t b;
        b = sb.pop_front();
        chk("sb_beat", {27'd0, m_out_write, m_out_id, m_out_addr}, {27'd0, b.write, b.id, b.addr});
        $display("beat addr=%08h id=%h write=%0d", m_out_addr, m_out_id, m_out_write);
      end
    end
  end

  initial begin
    in0_id = 4'hD;  in1_id = 4'h3;
    in0_burst = 2'b01;  in1_burst = 2'b01;
    in0_wstrb = 4'hF;   in1_wstrb = 4'h3;
    in0_bready = 1'b1;  in1_bready = 1'b0;
    in0_rready = 1'b0;  in1_rready = 1'b1;
    out_bresp = 2'b00;  out_rresp = 2'b00;  out_rlast = 1'b1;
    f_rst = 1'b1;
    drive(0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 4'd0);

    //   rst v0 v1 wr len acc bv bid   ev ep a0 a1
    add(1, 1, 1, 0, 0, 0, 0, 4'h0, 1, 0, 0, 0);  // reset: IDLE rules, port 0 preferred
    add(0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0);
    add(0, 1, 1, 0, 0, 1, 0, 4'h0, 1, 0, 1, 0);  // alternating reads
    add(0, 1, 1, 0, 0, 1, 1, 4'hA, 1, 1, 0, 1);
    add(0, 1, 1, 0, 0, 1, 1, 4'h2, 1, 0, 1, 0);
    add(0, 1, 1, 0, 0, 1, 0, 4'h0, 1, 1, 0, 1);
    add(0, 1, 0, 1, 3, 1, 0, 4'h0, 1, 0, 1, 0);  // len=3 write burst, beat 1
    add(0, 1, 1, 1, 3, 1, 0, 4'h0, 1, 0, 1, 0);  // beat 2, port 1 requests
    add(0, 1, 1, 1, 3, 0, 0, 4'h0, 1, 0, 0, 0);  // stall inside burst
    add(0, 1, 1, 1, 3, 1, 0, 4'h0, 1, 0, 1, 0);  // beat 3
    add(0, 1, 1, 1, 3, 1, 0, 4'h0, 1, 0, 1, 0);  // beat 4 completes
    add(0, 1, 1, 1, 3, 1, 0, 4'h0, 1, 1, 0, 1);  // port 1 read next
    add(0, 1, 1, 1, 0, 1, 0, 4'h0, 1, 0, 1, 0);  // single write, len=0
    add(0, 1, 1, 0, 0, 1, 0, 4'h0, 1, 1, 0, 1);
    add(0, 0, 1, 0, 0, 0, 1, 4'hF, 1, 1, 0, 0);  // port 1 held unaccepted
    add(0, 0, 1, 0, 0, 0, 0, 4'h0, 1, 1, 0, 0);
    add(0, 1, 1, 0, 0, 0, 0, 4'h0, 1, 1, 0, 0);  // port 0 joins, grant frozen
    add(0, 1, 1, 0, 0, 0, 0, 4'h0, 1, 1, 0, 0);
    add(0, 1, 1, 0, 0, 0, 0, 4'h0, 1, 1, 0, 0);
    add(0, 1, 1, 0, 0, 1, 0, 4'h0, 1, 1, 0, 1);
    add(0, 1, 0, 0, 0, 1, 0, 4'h0, 1, 0, 1, 0);  // port 0 served next
    add(0, 1, 0, 1, 7, 1, 0, 4'h0, 1, 0, 1, 0);  // len=7 burst beat 1
    add(1, 1, 1, 1, 7, 1, 0, 4'h0, 1, 0, 1, 0);  // reset at beat 2
    add(0, 1, 1, 0, 0, 0, 0, 4'h0, 1, 0, 0, 0);  // rr back to port 0
    add(0, 1, 1, 0, 0, 1, 0, 4'h0, 1, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 1, 4'h9, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0);

    @(posedge clk); #1;
    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v;
      logic [15:0] r_exp, r_act;
      v = vecs[i];
      drive(i, v.rst, v.v0, v.v1, v.wr0, v.len0, v.acc, v.bv, v.bid);
      if (v.e_valid && v.acc) sb.push_back(exp_beat(v.e_port, i, v.wr0));
      @(negedge clk);
      chk($sformatf("vec%0d_req", i),
          {60'd0, m_out_valid, m_out_valid & m_out_id[3], m_in0_accept, m_in1_accept},
          {60'd0, v.e_valid, v.e_valid & v.e_port, v.e_a0, v.e_a1});
      r_exp = {v.bv & ~v.bid[3], v.bv & v.bid[3], 1'b0, v.bid[2:0], ~v.bid[3],
               v.bv & ~v.bid[3], v.bv & v.bid[3], 1'b0, v.bid[2:0], v.bid[3], 2'b00};
      r_act = {m_in0_bvalid, m_in1_bvalid, m_in1_bid, m_out_bready,
               m_in0_rvalid, m_in1_rvalid, m_in0_rid, m_out_rready, 2'b00};
      chk($sformatf("vec%0d_resp", i), {48'd0, r_act}, {48'd0, r_exp});
      chk($sformatf("vec%0d_rdata", i), {m_in0_rdata, m_in1_rdata},
          {32'hCAFE_0000 + 32'(i), 32'hCAFE_0000 + 32'(i)});
      $display("vec %0d: valid=%0d id=%h acc0=%0d acc1=%0d", i, m_out_valid, m_out_id,
               m_in0_accept, m_in1_accept);
      @(posedge clk); #1;
    end

    // Fixed priority: port 1 must never win while port 0 keeps requesting.
    f_rst = 1'b1;
    drive(100, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 4'd0);
    @(posedge clk); #1;
    f_rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      drive(101 + k, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 4'd0);
      sb.push_back(exp_beat(1'(k & 1), 101 + k, 1'b0));
      @(negedge clk);
      chk($sformatf("fixed%0d_acc", k), {62'd0, f_in0_accept, f_in1_accept}, 64'd2);
      chk($sformatf("rr%0d_acc", k), {62'd0, m_in0_accept, m_in1_accept},
          (k & 1) ? 64'd1 : 64'd2);
      $display("prio %0d: fixed acc0=%0d acc1=%0d rr id=%h", k, f_in0_accept, f_in1_accept,
               m_out_id);
      @(posedge clk); #1;
    end
    drive(200, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 4'd0);
    @(negedge clk);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/usb_sniffer_axi_arb.md
USB_SNIFFER_AXI_ARB -- requirements
Module: usb_sniffer_axi_arb

Interface
REQ-001 Parameter: FIXED_PRIO, default 0, meaning 1 = port 0 always wins, with no round-robin.
REQ-002 clk_i  in  1  clock, rising edge.
REQ-003 rst_i  in  1  reset, asynchronous, active-high.
REQ-004 Ports in0_*, in1_* and out_* SHALL share one bundle; N=0,1. Directions are given for inN_; out_ is mirrored.
REQ-005 inN_valid_i / out_valid_o  in/out  1  request beat valid.
REQ-006 inN_write_i / out_write_o  in/out  1  1 = write beat, 0 = read request.
REQ-007 inN_addr_i / out_addr_o  in/out  32  address.
REQ-008 inN_id_i / out_id_o  in/out  4  transaction ID; out_id_o[3] = source port.
REQ-009 inN_len_i / out_len_o  in/out  8  burst length minus one.
REQ-010 inN_burst_i / out_burst_o  in/out  2  burst type.
REQ-011 inN_wdata_i / out_wdata_o  in/out  32  write data.
REQ-012 inN_wstrb_i / out_wstrb_o  in/out  4  byte strobes.
REQ-013 inN_accept_o / out_accept_i  out/in  1  beat accepted.
REQ-014 inN_bvalid_o, inN_bresp_o[1:0], inN_bid_o[3:0]  out  write response; sourced from out_bvalid_i, out_bresp_i, out_bid_i.
REQ-015 inN_bready_i / out_bready_o  in/out  1  write response ready.
REQ-016 inN_rvalid_o, inN_rdata_o[31:0], inN_rresp_o[1:0], inN_rid_o[3:0], inN_rlast_o  out  read data; sourced from out_r*_i.
REQ-017 inN_rready_i / out_rready_o  in/out  1  read data ready.

Function
REQ-018 States: IDLE (no grant held), HOLD (granted request offered but not accepted), BURST (write burst in progress).
REQ-019 IDLE, grant selection: one port valid -> grant it; both valid -> grant port rr_q (FIXED_PRIO=1 -> port 0); none valid -> out_valid_o=0.
REQ-020 Request fields SHALL pass combinationally from the granted port to out_*; out_id_o = {grant, inG_id_i[2:0]}; zero added latency.
REQ-021 inG_accept_o = out_accept_i for the granted port; the other accept SHALL be 0.
REQ-022 IDLE->HOLD: out_valid_o=1 and out_accept_i=0; grant is frozen until accept.
REQ-023 IDLE/HOLD, accepted write beat with len>0 -> BURST; beats_q=len; grant frozen.
REQ-024 BURST: each accepted beat decrements beats_q; the accept with beats_q==1 -> IDLE.
REQ-025 BURST: out_valid_o follows only the granted port; the other port is stalled regardless of its valid.
REQ-026 Transaction complete = accepted read request, accepted write beat with len==0 outside BURST, or final BURST beat. On completion, rr_q SHALL toggle to the non-granted port, even if that port is idle.
REQ-027 HOLD/BURST->IDLE SHALL occur in the same cycle as the completing accept; a new grant is evaluated the next cycle.
REQ-028 Granted port dropping valid in HOLD: return to IDLE with no rr_q change. This is a protocol violation; an assertion flags it.
REQ-029 Write response routing: out_bid_i[3] selects the port; inN_bvalid_o = out_bvalid_i & (bid[3]==N); inN_bid_o = {1'b0, out_bid_i[2:0]}; out_bready_o = selected port's bready.
REQ-030 Read response routing SHALL match REQ-029 using out_rid_i[3], covering rvalid/rdata/rresp/rlast and rready.
REQ-031 Requesters SHALL drive id[3]=0; the arbiter ignores inN_id_i[3].
REQ-032 Response paths are combinational and independent of grant state; responses may interleave with requests.

Reset
REQ-033 On rst_i: state=IDLE, beats_q=0, rr_q=0 (port 0 preferred), frozen grant cleared.
REQ-034 While in reset, all valid/accept outputs SHALL follow inputs combinationally per IDLE rules.
REQ-035 Reset mid-burst abandons the burst; no beats are replayed.

Structure
REQ-036 Package usb_sniffer_axi_arb_pkg SHALL hold the state encoding, ID_PORT_BIT=3 and the burst counter width (8).
REQ-037 Sub-module usb_sniffer_axi_arb_rr SHALL implement the 2-way round-robin picker: request[1:0], rr pointer -> one-hot grant.

Verification
REQ-038 Both ports valid, reads, out_accept_i=1 every cycle -> out_id_o[3] alternates 0,1,0,1; each inN_accept_o pulses on alternate cycles.
REQ-039 Port 0 write len=3, port 1 read asserted at beat 2 -> four port-0 beats contiguous with in1_accept_o=0; port-1 read issued the cycle after beat 4.
REQ-040 Port 1 valid, out_accept_i=0 for 5 cycles, port 0 raises valid at cycle 2 -> grant stays on port 1 until accept; port 0 is served next.
REQ-041 out_bvalid_i=1, out_bid_i=4'hA -> in1_bvalid_o=1, in1_bid_o=4'h2, in0_bvalid_o=0; out_bready_o = in1_bready_i.
REQ-042 rst_i asserted during beat 2 of a len=7 burst -> next cycle state IDLE, rr_q=0; both ports valid -> port 0 granted.
REQ-043 FIXED_PRIO=1, both ports continuously valid with reads -> port 1 never accepted.
